// File: rtl/handshake_rr_mux_if.sv
// Handshake bundle between the source/destination side and the round-robin mux.
// The master side drives strobes, data and backpressure; the mux sits on the slave side.
interface handshake_rr_mux_if #(
  parameter int WIDTH = 8,
  parameter int CH    = 4
);
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

  logic [CH-1:0]       sready;
  logic [CH*WIDTH-1:0] din;
  logic                dbusy;
  logic [CH-1:0]       sidle;
  logic                dvalid;
  logic [WIDTH-1:0]    dout;
  logic [CHW-1:0]      dch;
  logic [CH-1:0]       done;

  modport master (
    output sready, din, dbusy,
    input  sidle, dvalid, dout, dch, done
  );

  modport slave (
    input  sready, din, dbusy,
    output sidle, dvalid, dout, dch, done
  );
endinterface

// File: rtl/handshake_rr_mux.sv
// Round-robin multiplexer: per-channel one-entry slots drained one at a time
// through an IDLE/REQ/XFER/RELEASE controller with a fixed request-to-transfer delay.
module handshake_rr_mux #(
  parameter int WIDTH   = 8,
  parameter int CH      = 4,
  parameter int ACK_LAT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  handshake_rr_mux_if.slave   bus
);
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [2:0] CNT_LOAD = 3'(ACK_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_XFER    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t              state_r;
  logic [CH-1:0]       pending_r;
  logic [WIDTH-1:0]    slot_r [CH];
  logic [CHW-1:0]      rr_ptr_r;
  logic [CHW-1:0]      grant_r;
  logic [2:0]          cnt_r;
  logic                dvalid_r;
  logic [WIDTH-1:0]    dout_r;
  logic [CHW-1:0]      dch_r;
  logic [CH-1:0]       done_r;
  logic                pick_valid_s;
  logic [CHW-1:0]      pick_idx_s;

  // Channel index base+k wrapped modulo CH (k never exceeds CH-1).
  function automatic logic [CHW-1:0] rot_idx(input logic [CHW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= CH) begin
      s = s - CH;
    end else begin
      s = s;
    end
    return CHW'(s);
  endfunction

  // Scan from the highest offset down so the nearest pending channel at or after rr_ptr wins.
  always_comb begin
    pick_valid_s = 1'b0;
    pick_idx_s   = '0;
    for (int k = CH - 1; k >= 0; k--) begin
      if (pending_r[rot_idx(rr_ptr_r, k)]) begin
        pick_valid_s = 1'b1;
        pick_idx_s   = rot_idx(rr_ptr_r, k);
      end else begin
        pick_valid_s = pick_valid_s;
        pick_idx_s   = pick_idx_s;
      end
    end
  end

  // Slot capture and release; a pending slot (granted or not) ignores further strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= '0;
      for (int i = 0; i < CH; i++) begin
        slot_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        if ((state_r == ST_RELEASE) && (grant_r == CHW'(i))) begin
          pending_r[i] <= 1'b0;
        end else if (bus.sready[i] && !pending_r[i]) begin
          pending_r[i] <= 1'b1;
          slot_r[i]    <= bus.din[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Controller FSM with registered transfer and completion outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      rr_ptr_r <= '0;
      grant_r  <= '0;
      cnt_r    <= 3'd0;
      dvalid_r <= 1'b0;
      dout_r   <= '0;
      dch_r    <= '0;
      done_r   <= '0;
    end else begin
      dvalid_r <= 1'b0;
      done_r   <= '0;
      case (state_r)
        ST_IDLE: begin
          if (pick_valid_s && !bus.dbusy) begin
            grant_r <= pick_idx_s;
            cnt_r   <= CNT_LOAD;
            state_r <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (cnt_r != 3'd0) begin
            cnt_r <= cnt_r - 3'd1;
          end else if (!bus.dbusy) begin
            state_r <= ST_XFER;
          end
        end
        ST_XFER: begin
          dvalid_r <= 1'b1;
          dout_r   <= slot_r[grant_r];
          dch_r    <= grant_r;
          state_r  <= ST_RELEASE;
        end
        ST_RELEASE: begin
          done_r   <= CH'(1'b1) << grant_r;
          rr_ptr_r <= rot_idx(grant_r, 1);
          state_r  <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.sidle  = ~pending_r;
  assign bus.dvalid = dvalid_r;
  assign bus.dout   = dout_r;
  assign bus.dch    = dch_r;
  assign bus.done   = done_r;
endmodule

// File: tb/tb_handshake_rr_mux.sv
// Scenario tests for handshake_rr_mux plus a randomized run against a
// transaction-level reference model of the round-robin mux.
module tb_handshake_rr_mux;
  localparam int WIDTH   = 8;
  localparam int CH      = 4;
  localparam int ACK_LAT = 2;
  localparam int CHW     = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  handshake_rr_mux_if #(.WIDTH(WIDTH), .CH(CH)) bus ();

  handshake_rr_mux #(.WIDTH(WIDTH), .CH(CH), .ACK_LAT(ACK_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference model: slots, pending set, pointer and progress of the current transfer.
  logic [WIDTH-1:0] m_slot [CH];
  bit   [CH-1:0]    m_pend;
  int               m_ptr, m_grant, m_left;
  bit               m_act, m_xfer, m_rel;
  bit               m_dvalid;
  logic [WIDTH-1:0] m_dout;
  int               m_dch;
  bit   [CH-1:0]    m_done;

  function automatic void model_reset();
    for (int i = 0; i < CH; i++) m_slot[i] = '0;
    m_pend = '0; m_ptr = 0; m_grant = 0; m_left = 0;
    m_act = 0; m_xfer = 0; m_rel = 0;
    m_dvalid = 0; m_dout = '0; m_dch = 0; m_done = '0;
  endfunction

  function automatic void model_step(input logic [CH-1:0] sr, input logic [CH*WIDTH-1:0] d,
                                     input logic busy);
    bit [CH-1:0] old;
    int c;
    old = m_pend;
    m_dvalid = 0;
    m_done = '0;
    if (!m_act) begin
      if (!busy) begin
        for (int k = 0; k < CH; k++) begin
          c = (m_ptr + k) % CH;
          if (old[c] && !m_act) begin
            m_act = 1; m_grant = c; m_left = ACK_LAT; m_xfer = 0; m_rel = 0;
          end
        end
      end
    end else if (m_rel) begin
      m_done[m_grant] = 1'b1;
      m_pend[m_grant] = 1'b0;
      m_ptr = (m_grant + 1) % CH;
      m_act = 0; m_rel = 0;
    end else if (m_xfer) begin
      m_dvalid = 1; m_dout = m_slot[m_grant]; m_dch = m_grant;
      m_xfer = 0; m_rel = 1;
    end else if (m_left > 1) begin
      m_left = m_left - 1;
    end else if (!busy) begin
      m_xfer = 1;
    end
    for (int i = 0; i < CH; i++) begin
      if (sr[i] && !old[i]) begin
        m_slot[i] = d[i*WIDTH +: WIDTH];
        m_pend[i] = 1'b1;
      end
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step(bus.sready, bus.din, bus.dbusy);
    cyc++;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.sready = '0; bus.din = '0; bus.dbusy = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.sidle, bus.dvalid, bus.dout, bus.dch, bus.done} !== {4'b1111, 1'b0, 8'h00, 2'b00, 4'b0000}) begin
      n_errors++;
      $display("FAIL reset_values: got sidle=%b dvalid=%b dout=%h dch=%0d done=%b, expected 1111/0/00/0/0000",
               bus.sidle, bus.dvalid, bus.dout, bus.dch, bus.done);
    end
    apply_reset();
    n_checks++;
    if (bus.sidle !== 4'b1111) begin
      n_errors++;
      $display("FAIL sidle_after_reset: got %b expected 1111", bus.sidle);
    end
  endtask

  task automatic test_single();
    int n;
    apply_reset();
    bus.din = $urandom;
    bus.din[2*WIDTH +: WIDTH] = 8'hA5;
    bus.sready = 4'b0100;
    cycle();
    bus.sready = '0;
    bus.din = $urandom;
    n_checks++;
    if (bus.sidle !== 4'b1011) begin
      n_errors++;
      $display("FAIL single_sidle_fall: got %b expected 1011", bus.sidle);
    end
    for (n = 1; n <= 20; n++) begin
      cycle();
      if (bus.dvalid === 1'b1) break;
    end
    n_checks++;
    if (n !== 4 || bus.dout !== 8'hA5 || bus.dch !== 2'd2 || bus.done !== 4'b0000) begin
      n_errors++;
      $display("FAIL single_xfer: got latency=%0d dout=%h dch=%0d done=%b, expected 4/a5/2/0000",
               n, bus.dout, bus.dch, bus.done);
    end
    cycle();
    n_checks++;
    if (bus.done !== 4'b0100 || bus.sidle[2] !== 1'b1 || bus.dvalid !== 1'b0) begin
      n_errors++;
      $display("FAIL single_release: got done=%b sidle=%b dvalid=%b, expected 0100/1xxx/0",
               bus.done, bus.sidle, bus.dvalid);
    end
  endtask

  task automatic test_round_robin();
    int t [4];
    logic [CHW-1:0] ch [4];
    logic [WIDTH-1:0] dat [4];
    int np;
    apply_reset();
    bus.din = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.sready = 4'b1111;
    cycle();
    bus.sready = '0;
    np = 0;
    for (int i = 0; i < 60 && np < 4; i++) begin
      cycle();
      if (bus.dvalid === 1'b1) begin
        t[np] = cyc; ch[np] = bus.dch; dat[np] = bus.dout; np++;
      end
    end
    n_checks++;
    if (np !== 4) begin
      n_errors++;
      $display("FAIL rr_pulse_count: got %0d expected 4", np);
    end
    for (int j = 0; j < np; j++) begin
      n_checks++;
      if (ch[j] !== 2'(j) || dat[j] !== 8'h10 + 8'(j) || (j > 0 && t[j] - t[j-1] !== 5)) begin
        n_errors++;
        $display("FAIL rr_order[%0d]: got dch=%0d dout=%h gap=%0d, expected %0d/%h/5",
                 j, ch[j], dat[j], (j > 0) ? t[j] - t[j-1] : 5, j, 8'h10 + 8'(j));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] d;
    apply_reset();
    d = 8'($urandom);
    bus.din = '0;
    bus.din[0 +: WIDTH] = d;
    bus.sready = 4'b0001;
    cycle();
    bus.sready = '0;
    cycle();
    cycle();
    bus.dbusy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      n_checks++;
      if (bus.dvalid !== 1'b0) begin
        n_errors++;
        $display("FAIL bp_hold[%0d]: got dvalid=%b expected 0", i, bus.dvalid);
      end
    end
    bus.dbusy = 1'b0;
    cycle();
    n_checks++;
    if (bus.dvalid !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_release_early: got dvalid=%b expected 0", bus.dvalid);
    end
    cycle();
    n_checks++;
    if (bus.dvalid !== 1'b1 || bus.dout !== d || bus.dch !== 2'd0) begin
      n_errors++;
      $display("FAIL bp_release_xfer: got dvalid=%b dout=%h dch=%0d, expected 1/%h/0",
               bus.dvalid, bus.dout, bus.dch, d);
    end
  endtask

  task automatic test_overwrite();
    int n;
    apply_reset();
    bus.din = '0;
    bus.din[1*WIDTH +: WIDTH] = 8'h3C;
    bus.sready = 4'b0010;
    cycle();
    bus.sready = '0;
    cycle();
    bus.din[1*WIDTH +: WIDTH] = 8'hFF;
    bus.sready = 4'b0010;
    cycle();
    bus.sready = '0;
    for (n = 0; n < 20; n++) begin
      if (bus.dvalid === 1'b1) break;
      cycle();
    end
    n_checks++;
    if (bus.dvalid !== 1'b1 || bus.dout !== 8'h3C || bus.dch !== 2'd1) begin
      n_errors++;
      $display("FAIL overwrite_guard: got dvalid=%b dout=%h dch=%0d, expected 1/3c/1",
               bus.dvalid, bus.dout, bus.dch);
    end
  endtask

  task automatic test_wrap();
    logic [CHW-1:0] ch [2];
    int np;
    apply_reset();
    bus.din = $urandom;
    bus.sready = 4'b0100;
    cycle();
    bus.sready = '0;
    for (int i = 0; i < 20 && bus.done[2] !== 1'b1; i++) cycle();
    bus.din = {8'h3A, 8'h00, 8'h00, 8'h0A};
    bus.sready = 4'b1001;
    cycle();
    bus.sready = '0;
    np = 0;
    for (int i = 0; i < 40 && np < 2; i++) begin
      cycle();
      if (bus.dvalid === 1'b1) begin
        ch[np] = bus.dch; np++;
      end
    end
    n_checks++;
    if (np !== 2 || ch[0] !== 2'd3 || ch[1] !== 2'd0) begin
      n_errors++;
      $display("FAIL wrap_order: got pulses=%0d first=%0d second=%0d, expected 2/3/0",
               np, ch[0], ch[1]);
    end
  endtask

  task automatic test_midop_reset();
    int seen;
    apply_reset();
    bus.din = '0;
    bus.din[3*WIDTH +: WIDTH] = 8'h5E;
    bus.sready = 4'b1000;
    cycle();
    bus.sready = '0;
    for (int i = 0; i < 20 && bus.done[3] !== 1'b1; i++) cycle();
    bus.din[1*WIDTH +: WIDTH] = 8'h77;
    bus.sready = 4'b0010;
    cycle();
    bus.sready = '0;
    cycle();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.sidle, bus.dvalid, bus.dout, bus.dch, bus.done} !== {4'b1111, 1'b0, 8'h00, 2'b00, 4'b0000}) begin
      n_errors++;
      $display("FAIL midop_reset_values: got sidle=%b dvalid=%b dout=%h dch=%0d done=%b, expected 1111/0/00/0/0000",
               bus.sidle, bus.dvalid, bus.dout, bus.dch, bus.done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (bus.dvalid !== 1'b0 || bus.done !== 4'b0000) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_errors++;
      $display("FAIL midop_discard: got %0d cycles with dvalid/done after reset, expected 0", seen);
    end
  endtask

  task automatic test_random();
    logic [CHW+WIDTH+2*CH:0] exp_v, got_v;
    apply_reset();
    for (int i = 0; i < 1500; i++) begin
      bus.sready = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      bus.din = $urandom;
      bus.dbusy = ($urandom_range(0, 3) == 0);
      cycle();
      exp_v = {m_dvalid, m_dout, 2'(m_dch), m_done, ~m_pend};
      got_v = {bus.dvalid, bus.dout, bus.dch, bus.done, bus.sidle};
      n_checks++;
      if (got_v !== exp_v) begin
        n_errors++;
        $display("FAIL random_cycle[%0d]: got dvalid/dout/dch/done/sidle=%h expected %h", i, got_v, exp_v);
      end
    end
    bus.sready = '0;
    bus.dbusy = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.sready = '0;
    bus.din = '0;
    bus.dbusy = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_overwrite();
    test_wrap();
    test_midop_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
